iir_response_monitor: RTL and testbench

- Sits on the output side of pipelined_iir: consumes filtered samples y and measures the steady-state output amplitude.
- Delivers a synthesizable pass/stop verdict in place of waveform inspection of a sine stimulus.
- Samples are signed Q20 (1.0 = 1048576), 48 kHz sample rate, one sample per clock when valid.
- After a settle period it tracks per-window peak |y| over several windows and reports the peak, the minimum and maximum window peaks, and passband/stopband flags.

---
 rtl/iir_mon_pkg.sv | 25 ++
 rtl/iir_abs_sat.sv | 28 ++
 rtl/iir_response_monitor.sv | 177 +++++++++++++++++
 tb/tb_iir_response_monitor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_mon_pkg.sv
// Shared definitions for the IIR response monitor family.
//
// Contents:
//   mon_state_t   - run-control states (idle, settle, measure, done)
//   Q20_ONE       - 1.0 in signed Q20
//   Q20_PASS_MIN  - 0.9 in Q20, default passband threshold
//   Q20_STOP_MAX  - 0.1 in Q20, default stopband threshold
//   SAMPLE_WIDTH  - default filter sample width
package iir_mon_pkg;

  // Run-control states. The ST_ prefix keeps these names distinct from the
  // monitor's SETTLE parameter, which shares the plain name.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } mon_state_t;

  localparam int Q20_ONE      = 1048576;
  localparam int Q20_PASS_MIN = 943718;
  localparam int Q20_STOP_MAX = 104858;
  localparam int SAMPLE_WIDTH = 32;

endpackage

// File: rtl/iir_abs_sat.sv
// Combinational saturating absolute value of a signed two's complement word.
//
// Ports:
//   i_value - signed input sample (WIDTH bits)
//   o_abs   - unsigned |i_value|; the most negative input saturates to the
//             largest positive value instead of wrapping back to itself
module iir_abs_sat #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_value,
  output logic [WIDTH-1:0] o_abs
);

  localparam logic [WIDTH-1:0] LP_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LP_MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  // Negating the most negative value would overflow, so it is clamped.
  always_comb begin
    if (i_value == LP_MOST_NEG) begin
      o_abs = LP_MAX_POS;
    end else if (i_value[WIDTH-1]) begin
      o_abs = (~i_value) + 1'b1;
    end else begin
      o_abs = i_value;
    end
  end

endmodule

// File: rtl/iir_response_monitor.sv
// Steady-state amplitude monitor for the output of pipelined_iir.
// After discarding SETTLE valid samples (filter transient) it measures the
// peak |y| of NUM_WIN consecutive windows of WINDOW valid samples each and
// gives a passband / stopband verdict from the smallest / largest window peak.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-high reset
//   start     - begin a run (only honoured in idle)
//   y_in      - signed filter output sample
//   y_valid   - y_in carries a sample this cycle
//   busy      - run in progress (settling or measuring)
//   done      - one-cycle pulse when a run completes
//   peak      - peak |y| of the most recently completed window
//   min_peak  - smallest window peak of the current run
//   max_peak  - largest window peak of the current run
//   win_count - windows completed in the current run
//   passband  - every window peak >= PASS_MIN (valid from done until next start)
//   stopband  - every window peak <= STOP_MAX (same validity as passband)
module iir_response_monitor
  import iir_mon_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_WIDTH,
  parameter int SETTLE   = 96,
  parameter int WINDOW   = 24,
  parameter int NUM_WIN  = 4,
  parameter int PASS_MIN = Q20_PASS_MIN,
  parameter int STOP_MAX = Q20_STOP_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] y_in,
  input  logic             y_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] peak,
  output logic [WIDTH-1:0] min_peak,
  output logic [WIDTH-1:0] max_peak,
  output logic [7:0]       win_count,
  output logic             passband,
  output logic             stopband
);

  localparam logic [31:0]      LP_SETTLE      = 32'(SETTLE);
  localparam logic [31:0]      LP_WIN_LAST    = 32'(WINDOW - 1);
  localparam logic [7:0]       LP_NUMWIN_LAST = 8'(NUM_WIN - 1);
  localparam logic [WIDTH-1:0] LP_PASS        = WIDTH'(PASS_MIN);
  localparam logic [WIDTH-1:0] LP_STOP        = WIDTH'(STOP_MAX);
  localparam logic [WIDTH-1:0] LP_MIN_INIT    = {1'b0, {(WIDTH-1){1'b1}}};

  mon_state_t       r_state;
  logic [31:0]      r_settleCnt;
  logic [31:0]      r_sampCnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_peak;
  logic [WIDTH-1:0] r_minTrk;
  logic [WIDTH-1:0] r_minPeak;
  logic [WIDTH-1:0] r_max;
  logic [7:0]       r_winCount;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_stop;

  logic [WIDTH-1:0] w_absY;
  logic [WIDTH-1:0] w_winPeak;
  logic [WIDTH-1:0] w_newMin;
  logic [WIDTH-1:0] w_newMax;
  logic             w_lastInWin;
  logic             w_lastWin;

  iir_abs_sat #(
    .WIDTH(WIDTH)
  ) u_abs (
    .i_value(y_in),
    .o_abs  (w_absY)
  );

  // The window peak folds in the current sample so the window-end edge can
  // publish it without an extra cycle; min/max/verdicts build on that value.
  assign w_winPeak   = (w_absY > r_acc) ? w_absY : r_acc;
  assign w_newMin    = (w_winPeak < r_minTrk) ? w_winPeak : r_minTrk;
  assign w_newMax    = (w_winPeak > r_max) ? w_winPeak : r_max;
  assign w_lastInWin = (r_sampCnt == LP_WIN_LAST);
  assign w_lastWin   = (r_winCount == LP_NUMWIN_LAST);

  // Run control and measurement. Every state change requires a valid sample
  // except the start and done transitions, so y_valid gaps only stretch time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_settleCnt <= '0;
      r_sampCnt   <= '0;
      r_acc       <= '0;
      r_peak      <= '0;
      r_minTrk    <= LP_MIN_INIT;
      r_minPeak   <= '0;
      r_max       <= '0;
      r_winCount  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_stop      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_winCount  <= '0;
            r_max       <= '0;
            r_minTrk    <= LP_MIN_INIT;
            r_minPeak   <= '0;
            r_pass      <= 1'b0;
            r_stop      <= 1'b0;
            r_settleCnt <= LP_SETTLE;
            r_acc       <= '0;
            r_sampCnt   <= '0;
            r_busy      <= 1'b1;
            if (SETTLE == 0) begin
              r_state <= ST_MEASURE;
            end else begin
              r_state <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (y_valid) begin
            r_settleCnt <= r_settleCnt - 32'd1;
            if (r_settleCnt == 32'd1) begin
              r_state <= ST_MEASURE;
            end
          end
        end
        ST_MEASURE: begin
          if (y_valid) begin
            if (w_lastInWin) begin
              r_peak     <= w_winPeak;
              r_minTrk   <= w_newMin;
              r_minPeak  <= w_newMin;
              r_max      <= w_newMax;
              r_winCount <= r_winCount + 8'd1;
              r_acc      <= '0;
              r_sampCnt  <= '0;
              if (w_lastWin) begin
                r_pass  <= (w_newMin >= LP_PASS);
                r_stop  <= (w_newMax <= LP_STOP);
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_DONE;
              end
            end else begin
              r_acc     <= w_winPeak;
              r_sampCnt <= r_sampCnt + 32'd1;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign peak      = r_peak;
  assign min_peak  = r_minPeak;
  assign max_peak  = r_max;
  assign win_count = r_winCount;
  assign passband  = r_pass;
  assign stopband  = r_stop;

endmodule

// File: tb/tb_iir_response_monitor.sv
// Self-checking bench for iir_response_monitor with default parameters.
// A behavioural model collects the valid sample stream, slices it into the
// settle region and measurement windows with plain arithmetic, and derives
// window peaks, win_count progress, verdicts and the done cycle.
module tb_iir_response_monitor;

  localparam int WIDTH    = 32;
  localparam int SETTLE   = 96;
  localparam int WINDOW   = 24;
  localparam int NUM_WIN  = 4;
  localparam int PASS_MIN = 943718;
  localparam int STOP_MAX = 104858;
  localparam int Q20_ONE  = 1048576;
  localparam int MAX_CYC  = 1500;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] y_in;
  logic             y_valid;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] peak;
  logic [WIDTH-1:0] min_peak;
  logic [WIDTH-1:0] max_peak;
  logic [7:0]       win_count;
  logic             passband;
  logic             stopband;

  int checks   = 0;
  int failures = 0;

  // Model results of the most recent run, used by the directed checks.
  longint mPeak;
  longint mMin;
  longint mMax;
  bit     mPass;
  bit     mStop;
  int     obsDoneCycle;

  iir_response_monitor dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .y_in     (y_in),
    .y_valid  (y_valid),
    .busy     (busy),
    .done     (done),
    .peak     (peak),
    .min_peak (min_peak),
    .max_peak (max_peak),
    .win_count(win_count),
    .passband (passband),
    .stopband (stopband)
  );

  // 10 time-unit clock; inputs change and outputs are sampled on negedges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Magnitude with clamping to the largest positive 32-bit value.
  function automatic longint absModel(input logic signed [31:0] v);
    longint a;
    a = v;
    if (a < 0) a = -a;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    return a;
  endfunction

  // Sample generator; n is the index among counted (valid) samples.
  // kind 0: sine of amplitude amp, 24 samples per period
  // kind 1: zeros
  // kind 2: single most-negative sample in the first window, zeros elsewhere
  // kind 3: uniform noise in [-amp, amp]
  // kind 4: unrestricted random words
  function automatic logic [31:0] genSample(input int kind, input int amp, input int n);
    real ph;
    int  r;
    case (kind)
      0: begin
        ph = 2.0 * 3.14159265358979 * real'(n) / 24.0;
        r  = int'(real'(amp) * $sin(ph));
        return 32'(r);
      end
      1: return 32'd0;
      2: return (n == SETTLE + 5) ? 32'h8000_0000 : 32'd0;
      3: begin
        r = int'($urandom_range(0, 2 * amp)) - amp;
        return 32'(r);
      end
      default: return $urandom;
    endcase
  endfunction

  // Runs one complete measurement while checking progress every cycle.
  // vmode 0: always valid, 1: valid on even cycles, 2: random gaps.
  // busyStartAt: cycle on which start is re-asserted mid-run (0 = never).
  // startWithValid: a valid sample accompanies start and must be ignored.
  task automatic applyStimulus(input int kind, input int amp, input int vmode,
                               input int busyStartAt, input bit startWithValid);
    longint pk[NUM_WIN];
    int     needed;
    int     nValid;
    int     lastK;
    int     expWc;
    int     idx;
    bit     v;
    logic [31:0] s;
    longint a;

    needed = SETTLE + WINDOW * NUM_WIN;
    for (int w = 0; w < NUM_WIN; w++) pk[w] = 0;
    nValid       = 0;
    lastK        = -1;
    obsDoneCycle = -1;

    start   = 1'b1;
    y_valid = startWithValid;
    y_in    = startWithValid ? 32'h7fff_0000 : 32'd0;
    @(negedge clk);
    start = 1'b0;

    for (int k = 1; k <= MAX_CYC && obsDoneCycle < 0; k++) begin
      case (vmode)
        0: v = 1'b1;
        1: v = (k % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (nValid >= needed) v = 1'b0;
      start   = (k == busyStartAt);
      y_valid = v;
      if (v) begin
        s   = genSample(kind, amp, nValid);
        idx = nValid;
        if (idx >= SETTLE) begin
          a = absModel(s);
          if (a > pk[(idx - SETTLE) / WINDOW]) pk[(idx - SETTLE) / WINDOW] = a;
        end
        nValid++;
        if (nValid == needed) lastK = k;
      end else begin
        s = $urandom;
      end
      y_in = s;
      @(negedge clk);
      start = 1'b0;

      expWc = (nValid <= SETTLE) ? 0 : (nValid - SETTLE) / WINDOW;
      if (expWc > NUM_WIN) expWc = NUM_WIN;
      if (expWc > 0) mPeak = pk[expWc - 1];
      if (done === 1'b1) obsDoneCycle = k;
      checkOutput("win_count_progress", win_count, expWc);
      checkOutput("peak_progress", peak, mPeak);
      checkOutput("busy_progress", busy, (obsDoneCycle < 0) ? 1 : 0);
    end
    y_valid = 1'b0;

    mMin = pk[0];
    mMax = pk[0];
    for (int w = 1; w < NUM_WIN; w++) begin
      if (pk[w] < mMin) mMin = pk[w];
      if (pk[w] > mMax) mMax = pk[w];
    end
    mPass = (mMin >= PASS_MIN);
    mStop = (mMax <= STOP_MAX);

    checkOutput("done_cycle", obsDoneCycle, lastK);
    checkOutput("min_peak", min_peak, mMin);
    checkOutput("max_peak", max_peak, mMax);
    checkOutput("passband", passband, mPass);
    checkOutput("stopband", stopband, mStop);

    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("passband_held", passband, mPass);
    checkOutput("win_count_held", win_count, NUM_WIN);
  endtask

  initial begin
    int doneCount;

    reset   = 1'b1;
    start   = 1'b0;
    y_valid = 1'b0;
    y_in    = '0;
    mPeak   = 0;
    repeat (2) @(negedge clk);

    // Reset state: every output reads zero.
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_peak", peak, 0);
    checkOutput("rst_min_peak", min_peak, 0);
    checkOutput("rst_max_peak", max_peak, 0);
    checkOutput("rst_win_count", win_count, 0);
    checkOutput("rst_passband", passband, 0);
    checkOutput("rst_stopband", stopband, 0);
    reset = 1'b0;
    @(negedge clk);

    // Full-scale 2 kHz sine: passband verdict, done 192 cycles after start.
    applyStimulus(0, Q20_ONE, 0, 0, 1'b0);
    checkOutput("sine1_done_cycle", obsDoneCycle, 192);
    checkOutput("sine1_peak", peak, Q20_ONE);
    checkOutput("sine1_min", min_peak, Q20_ONE);
    checkOutput("sine1_max", max_peak, Q20_ONE);
    checkOutput("sine1_pass", passband, 1);
    checkOutput("sine1_stop", stopband, 0);

    // Silence: stopband verdict, all peaks zero.
    applyStimulus(1, 0, 0, 0, 1'b0);
    checkOutput("zero_peak", peak, 0);
    checkOutput("zero_max", max_peak, 0);
    checkOutput("zero_stop", stopband, 1);
    checkOutput("zero_pass", passband, 0);

    // Half amplitude: neither verdict.
    applyStimulus(0, 524288, 0, 0, 1'b0);
    checkOutput("half_peak", peak, 524288);
    checkOutput("half_pass", passband, 0);
    checkOutput("half_stop", stopband, 0);

    // Most negative sample saturates rather than wrapping.
    applyStimulus(2, 0, 0, 0, 1'b0);
    checkOutput("sat_max", max_peak, 64'sd2147483647);
    checkOutput("sat_min", min_peak, 0);
    checkOutput("sat_last_peak", peak, 0);

    // Valid every other cycle: same verdict, twice the duration.
    applyStimulus(0, Q20_ONE, 1, 0, 1'b0);
    checkOutput("gap_done_cycle", obsDoneCycle, 384);
    checkOutput("gap_pass", passband, 1);
    checkOutput("gap_peak", peak, Q20_ONE);

    // Start while busy is ignored; sample alongside the accepted start is not counted.
    applyStimulus(0, Q20_ONE, 0, 50, 1'b1);
    checkOutput("busy_start_done_cycle", obsDoneCycle, 192);
    checkOutput("busy_start_pass", passband, 1);

    // Randomized runs around the thresholds with random valid gaps.
    applyStimulus(0, int'($urandom_range(900000, 1000000)), 2, 0, 1'b1);
    applyStimulus(3, int'($urandom_range(80000, 130000)), 2, int'($urandom_range(1, 150)), 1'b0);
    applyStimulus(3, 2000000, 2, 0, 1'b1);
    applyStimulus(4, 0, 2, 0, 1'b0);

    // Reset in the middle of measurement aborts the run without a done pulse.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 120; k++) begin
      y_valid = 1'b1;
      y_in    = genSample(0, Q20_ONE, k);
      @(negedge clk);
    end
    checkOutput("mid_win_count", win_count, 1);
    checkOutput("mid_peak", peak, Q20_ONE);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_busy", busy, 0);
    checkOutput("async_peak", peak, 0);
    checkOutput("async_max", max_peak, 0);
    checkOutput("async_min", min_peak, 0);
    checkOutput("async_win_count", win_count, 0);
    checkOutput("async_pass", passband, 0);
    @(negedge clk);
    reset = 1'b0;
    mPeak = 0;
    doneCount = 0;
    for (int k = 0; k < 300; k++) begin
      y_valid = 1'b1;
      y_in    = $urandom;
      @(negedge clk);
      if (done !== 1'b0) doneCount++;
    end
    y_valid = 1'b0;
    checkOutput("abort_no_done", doneCount, 0);
    checkOutput("abort_idle_busy", busy, 0);
    checkOutput("abort_win_count", win_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
